// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding decode.
// Holds the PC, issues word fetches over a valid/ready request channel with
// in-order responses, buffers returned instructions in a DEPTH-entry FIFO and
// presents them with their PC to decode. Redirects from execute flush the FIFO
// and drop every response still in flight.
// Optional feature: define IFU_MISALIGN_CHK_EN to halt fetch on a redirect
// target with pc[1:0] != 0 (flagged on fetch_misalign); an aligned redirect
// clears it. Without the macro the raw target is fetched and the flag is 0.
module ifu_fetch #(
    parameter int              PC_W     = 64,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              fetch_misalign
);

    localparam int         AW      = $clog2(DEPTH);
    localparam int         CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic              run_q;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CW-1:0]     out_cnt_q, out_cnt_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;

    // PC tags of outstanding requests, in issue order
    logic [PC_W-1:0]   tag_q [DEPTH];
    logic [AW-1:0]     tag_wr_q, tag_rd_q;

    // instruction FIFO storage
    logic [INST_W-1:0] fdata_q [DEPTH];
    logic [PC_W-1:0]   fpc_q [DEPTH];
    logic [AW-1:0]     f_wr_q, f_wr_d, f_rd_q, f_rd_d;

    // registered head presented to decode
    logic [INST_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   inst_pc_q, inst_pc_d;

    logic              halt;
    logic              credit_ok;
    logic              req_fire;
    logic              rsp_keep;
    logic              pop;
    logic [PC_W-1:0]   rsp_tag;

`ifdef IFU_MISALIGN_CHK_EN
    logic halt_q;

    // Each redirect re-evaluates the target alignment; a misaligned one parks fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else if (redirect_valid) begin
            halt_q <= |redirect_pc[1:0];
        end
    end

    assign halt           = halt_q;
    assign fetch_misalign = halt_q;
`else
    assign halt           = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    // In-flight plus buffered fetches never exceed DEPTH, so the FIFO cannot overflow.
    assign credit_ok      = ({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < DEPTH_C;
    assign imem_req_valid = run_q & ~redirect_valid & ~halt & credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response is kept only if it is not owed to a pre-redirect request.
    assign rsp_tag    = tag_q[tag_rd_q];
    assign rsp_keep   = imem_rsp_valid & ~redirect_valid & (drop_cnt_q == '0);

    assign inst_valid = (fifo_cnt_q != '0);
    assign pop        = inst_valid & inst_ready;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    // Next-state for PC, credit/drop counters, FIFO pointers and the decode head.
    always_comb begin
        pc_d       = pc_q;
        out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_cnt_d = drop_cnt_q;
        f_rd_d     = f_rd_q + AW'(pop);
        f_wr_d     = f_wr_q + AW'(rsp_keep);
        fifo_cnt_d = fifo_cnt_q + CW'(rsp_keep) - CW'(pop);
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (req_fire) begin
            pc_d = pc_q + PC_W'(4);
        end

        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            drop_cnt_d = out_cnt_q - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end

        // The same-cycle pop has already been honoured; the rest is discarded.
        if (redirect_valid) begin
            f_rd_d     = f_wr_q;
            fifo_cnt_d = '0;
        end

        // Head register follows the new FIFO head; when empty it keeps its last value.
        if (fifo_cnt_d != '0) begin
            if (rsp_keep && (f_rd_d == f_wr_q)) begin
                inst_d    = imem_rsp_data;
                inst_pc_d = rsp_tag;
            end else begin
                inst_d    = fdata_q[f_rd_d];
                inst_pc_d = fpc_q[f_rd_d];
            end
        end
    end

    // Control state and decode-facing head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            pc_q       <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            f_wr_q     <= '0;
            f_rd_q     <= '0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
        end else begin
            run_q      <= 1'b1;
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            tag_wr_q   <= tag_wr_q + AW'(req_fire);
            tag_rd_q   <= tag_rd_q + AW'(imem_rsp_valid);
            f_wr_q     <= f_wr_d;
            f_rd_q     <= f_rd_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
        end
    end

    // Tag and FIFO storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr_q] <= pc_q;
        end
        if (rsp_keep) begin
            fdata_q[f_wr_q] <= imem_rsp_data;
            fpc_q[f_wr_q]   <= rsp_tag;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with an in-order memory model of configurable latency.
module tb_ifu_fetch;

    localparam int          PC_W   = 64;
    localparam int          INST_W = 32;
    localparam int          DEPTH  = 2;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_rsp_valid = 1'b0;
    logic [INST_W-1:0] imem_rsp_data = '0;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              fetch_misalign;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    int fire_cnt = 0;

    logic [63:0] mq_addr[$];
    int          mq_due[$];
    int          fire_cyc[$];
    logic [63:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    int          pop_cyc[$];

    ifu_fetch #(.PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_inst(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Memory model and decode monitor: sample at the edge, drive responses 1 time unit later.
    initial begin
        logic [63:0] t_addr;
        int          t_due;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst_n) begin
                mq_addr.delete();
                mq_due.delete();
            end else begin
                if (imem_rsp_valid && mq_addr.size() > 0) begin
                    t_addr = mq_addr.pop_front();
                    t_due  = mq_due.pop_front();
                end
                if (imem_req_valid && imem_req_ready) begin
                    mq_addr.push_back(imem_req_addr);
                    mq_due.push_back(cyc + mem_lat - 1);
                    fire_cnt = fire_cnt + 1;
                    fire_cyc.push_back(cyc);
                end
                if (inst_valid && inst_ready) begin
                    pop_pc.push_back(inst_pc);
                    pop_inst.push_back(inst);
                    pop_cyc.push_back(cyc);
                end
            end
            #1;
            if (rst_n && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = f_inst(mq_addr[0]);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic do_reset(input int lat);
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_lat = lat;
        fire_cnt = 0;
        fire_cyc.delete();
        pop_pc.delete();
        pop_inst.delete();
        pop_cyc.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst); end
        checks++; if (inst_pc !== 64'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
        checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", fetch_misalign); end
        checks++; if (imem_req_addr !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_req_addr, RST_PC); end
    endtask

    task automatic test_startup();
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset(1);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL start_no_req_before_run: got %b expected 0", imem_req_valid); end
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin errors++; $display("FAIL start_first_req: got v=%b a=%h expected v=1 a=%h", imem_req_valid, imem_req_addr, RST_PC); end
        for (int i = 0; i < 40 && pop_pc.size() < 8; i++) @(negedge clk);
        checks++; if (pop_pc.size() < 8) begin errors++; $display("FAIL start_pop_count: got %0d expected 8", pop_pc.size()); end
        for (int i = 0; i < 8 && i < pop_pc.size(); i++) begin
            checks++; if (pop_pc[i] !== RST_PC + 64'(4*i) || pop_inst[i] !== f_inst(RST_PC + 64'(4*i))) begin errors++; $display("FAIL start_seq[%0d]: got pc=%h inst=%h expected pc=%h", i, pop_pc[i], pop_inst[i], RST_PC + 64'(4*i)); end
        end
        if (pop_cyc.size() >= 2 && fire_cyc.size() >= 1) begin
            checks++; if (pop_cyc[0] - fire_cyc[0] !== 2) begin errors++; $display("FAIL start_latency: got %0d expected 2", pop_cyc[0] - fire_cyc[0]); end
            checks++; if (pop_cyc[1] - pop_cyc[0] !== 1) begin errors++; $display("FAIL start_back_to_back: got %0d expected 1", pop_cyc[1] - pop_cyc[0]); end
        end
    endtask

    task automatic test_backpressure();
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        do_reset(1);
        repeat (11) @(negedge clk);
        checks++; if (fire_cnt !== DEPTH) begin errors++; $display("FAIL bp_fire_count: got %0d expected %0d", fire_cnt, DEPTH); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stalled: got %b expected 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC || inst !== f_inst(RST_PC)) begin errors++; $display("FAIL bp_head_held: got v=%b pc=%h inst=%h expected v=1 pc=%h", inst_valid, inst_pc, inst, RST_PC); end
        inst_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_no_req_before_pop: got %b expected 0", imem_req_valid); end
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC + 64'd8) begin errors++; $display("FAIL bp_resume: got v=%b a=%h expected v=1 a=%h", imem_req_valid, imem_req_addr, RST_PC + 64'd8); end
        for (int i = 0; i < 40 && pop_pc.size() < 6; i++) @(negedge clk);
        checks++; if (pop_pc.size() < 6) begin errors++; $display("FAIL bp_pop_count: got %0d expected 6", pop_pc.size()); end
        for (int i = 0; i < 6 && i < pop_pc.size(); i++) begin
            checks++; if (pop_pc[i] !== RST_PC + 64'(4*i) || pop_inst[i] !== f_inst(RST_PC + 64'(4*i))) begin errors++; $display("FAIL bp_seq[%0d]: got pc=%h inst=%h expected pc=%h", i, pop_pc[i], pop_inst[i], RST_PC + 64'(4*i)); end
        end
    endtask

    task automatic test_redirect_drop();
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset(3);
        for (int i = 0; i < 10 && fire_cnt < 2; i++) @(negedge clk);
        checks++; if (fire_cnt !== 2) begin errors++; $display("FAIL drop_two_outstanding: got %0d expected 2", fire_cnt); end
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0100;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drop_no_req_on_redirect: got %b expected 0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (pop_pc.size() !== 0) begin errors++; $display("FAIL drop_no_early_pop: got %0d expected 0", pop_pc.size()); end
        pop_pc.delete(); pop_inst.delete(); pop_cyc.delete();
        for (int i = 0; i < 40 && pop_pc.size() < 3; i++) @(negedge clk);
        checks++; if (pop_pc.size() < 3) begin errors++; $display("FAIL drop_pop_count: got %0d expected 3", pop_pc.size()); end
        for (int i = 0; i < 3 && i < pop_pc.size(); i++) begin
            checks++; if (pop_pc[i] !== 64'h8000_0100 + 64'(4*i) || pop_inst[i] !== f_inst(64'h8000_0100 + 64'(4*i))) begin errors++; $display("FAIL drop_seq[%0d]: got pc=%h inst=%h expected pc=%h", i, pop_pc[i], pop_inst[i], 64'h8000_0100 + 64'(4*i)); end
        end
    endtask

    task automatic test_redirect_collide();
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        do_reset(1);
        for (int i = 0; i < 10 && fire_cnt < 2; i++) @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin errors++; $display("FAIL col_pre_head: got v=%b pc=%h expected v=1 pc=%h", inst_valid, inst_pc, RST_PC); end
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0300;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL col_no_req_on_redirect: got %b expected 0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL col_fifo_empty: got %b expected 0", inst_valid); end
        checks++; if (pop_pc.size() !== 1) begin errors++; $display("FAIL col_pop_count: got %0d expected 1", pop_pc.size()); end
        if (pop_pc.size() > 0) begin
            checks++; if (pop_pc[0] !== RST_PC) begin errors++; $display("FAIL col_head_consumed: got %h expected %h", pop_pc[0], RST_PC); end
        end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0300) begin errors++; $display("FAIL col_restart: got v=%b a=%h expected v=1 a=80000300", imem_req_valid, imem_req_addr); end
        pop_pc.delete(); pop_inst.delete(); pop_cyc.delete();
        for (int i = 0; i < 30 && pop_pc.size() < 2; i++) @(negedge clk);
        checks++; if (pop_pc.size() < 2) begin errors++; $display("FAIL col_new_pops: got %0d expected 2", pop_pc.size()); end
        for (int i = 0; i < 2 && i < pop_pc.size(); i++) begin
            checks++; if (pop_pc[i] !== 64'h8000_0300 + 64'(4*i) || pop_inst[i] !== f_inst(64'h8000_0300 + 64'(4*i))) begin errors++; $display("FAIL col_seq[%0d]: got pc=%h inst=%h expected pc=%h", i, pop_pc[i], pop_inst[i], 64'h8000_0300 + 64'(4*i)); end
        end
    endtask

    task automatic test_random_ready();
        logic        prev_valid;
        logic        prev_ready;
        logic [63:0] prev_addr;
        logic        have_prev;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset(2);
        have_prev = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b1;
        prev_addr = '0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (have_prev && prev_valid && !prev_ready) begin
                checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin errors++; $display("FAIL rnd_req_stable: got v=%b a=%h expected v=1 a=%h", imem_req_valid, imem_req_addr, prev_addr); end
            end
            prev_valid = imem_req_valid;
            prev_addr = imem_req_addr;
            imem_req_ready = 1'($urandom_range(0, 1));
            prev_ready = imem_req_ready;
            inst_ready = 1'($urandom_range(0, 1));
            have_prev = 1'b1;
        end
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (pop_pc.size() < 10) begin errors++; $display("FAIL rnd_pop_count: got %0d expected at least 10", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++; if (pop_pc[i] !== RST_PC + 64'(4*i) || pop_inst[i] !== f_inst(RST_PC + 64'(4*i))) begin errors++; $display("FAIL rnd_seq[%0d]: got pc=%h inst=%h expected pc=%h", i, pop_pc[i], pop_inst[i], RST_PC + 64'(4*i)); end
        end
    endtask

    task automatic test_misalign();
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset(1);
        repeat (6) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0102;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        pop_pc.delete(); pop_inst.delete(); pop_cyc.delete();
`ifdef IFU_MISALIGN_CHK_EN
        checks++; if (fetch_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag_set: got %b expected 1", fetch_misalign); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_halted_req[%0d]: got %b expected 0", i, imem_req_valid); end
            @(negedge clk);
        end
        checks++; if (pop_pc.size() !== 0) begin errors++; $display("FAIL mis_no_pops: got %0d expected 0", pop_pc.size()); end
`else
        checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_flag_off: got %b expected 0", fetch_misalign); end
        for (int i = 0; i < 20 && pop_pc.size() < 1; i++) @(negedge clk);
        checks++; if (pop_pc.size() < 1) begin errors++; $display("FAIL mis_raw_pop_count: got %0d expected 1", pop_pc.size()); end
        if (pop_pc.size() > 0) begin
            checks++; if (pop_pc[0] !== 64'h8000_0102 || pop_inst[0] !== f_inst(64'h8000_0102)) begin errors++; $display("FAIL mis_raw_addr: got pc=%h inst=%h expected pc=80000102", pop_pc[0], pop_inst[0]); end
        end
`endif
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_flag_clear: got %b expected 0", fetch_misalign); end
        pop_pc.delete(); pop_inst.delete(); pop_cyc.delete();
        for (int i = 0; i < 30 && pop_pc.size() < 2; i++) @(negedge clk);
        checks++; if (pop_pc.size() < 2) begin errors++; $display("FAIL mis_restart_count: got %0d expected 2", pop_pc.size()); end
        for (int i = 0; i < 2 && i < pop_pc.size(); i++) begin
            checks++; if (pop_pc[i] !== 64'h8000_0200 + 64'(4*i) || pop_inst[i] !== f_inst(64'h8000_0200 + 64'(4*i))) begin errors++; $display("FAIL mis_restart_seq[%0d]: got pc=%h inst=%h expected pc=%h", i, pop_pc[i], pop_inst[i], 64'h8000_0200 + 64'(4*i)); end
        end
    endtask

    task automatic test_reset_midop();
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset(1);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL mid_valids: got req=%b inst=%b expected 0 0", imem_req_valid, inst_valid); end
        checks++; if (inst !== 32'h0 || inst_pc !== 64'h0) begin errors++; $display("FAIL mid_head_cleared: got inst=%h pc=%h expected 0 0", inst, inst_pc); end
        checks++; if (imem_req_addr !== RST_PC) begin errors++; $display("FAIL mid_pc: got %h expected %h", imem_req_addr, RST_PC); end
        do_reset(1);
        for (int i = 0; i < 30 && pop_pc.size() < 2; i++) @(negedge clk);
        checks++; if (pop_pc.size() < 2) begin errors++; $display("FAIL mid_restart_count: got %0d expected 2", pop_pc.size()); end
        for (int i = 0; i < 2 && i < pop_pc.size(); i++) begin
            checks++; if (pop_pc[i] !== RST_PC + 64'(4*i)) begin errors++; $display("FAIL mid_restart_seq[%0d]: got %h expected %h", i, pop_pc[i], RST_PC + 64'(4*i)); end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collide();
        test_random_ready();
        test_misalign();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
